// File: rtl/reduce_gate_seq_v.sv
`default_nettype none
// ============================================================================
// Module      : reduce_gate_seq_v
// Description : Streams NUM_OPS operands of WIDTH bits, one per accepted beat,
//               and reduces them bitwise with XOR / NAND / NOR / XNOR chosen by
//               the code captured on the first beat. The registered result is
//               returned over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk    in   1      rising-edge clock
//   i_rst    in   1      asynchronous, active-high reset
//   i_code   in   2      00 XOR, 01 NAND, 10 NOR, 11 XNOR (first beat only)
//   i_valid  in   1      operand beat valid
//   i_data   in   WIDTH  operand
//   o_ready  out  1      a beat is accepted this cycle when i_valid is high
//   i_abort  in   1      drop partial transaction and return to IDLE
//   o_valid  out  1      result valid
//   o_data   out  WIDTH  result
//   i_ready  in   1      consumer accepts the result
//   o_busy   out  1      transaction in progress (ACCUM or DONE)
// ============================================================================
module reduce_gate_seq_v #(
  parameter int WIDTH   = 8,
  parameter int NUM_OPS = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [1:0]       i_code,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  input  logic             i_abort,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready,
  output logic             o_busy
);

  localparam int               CNT_W    = $clog2(NUM_OPS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_OPS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        code_q;
  logic              beat;
  logic [WIDTH-1:0]  acc_next;
  logic [WIDTH-1:0]  result;

  // Ready is decoded from state but forced low while reset is held, since the
  // reset state (IDLE) would otherwise advertise readiness during reset.
  assign o_ready = ~i_rst & (state != DONE);
  assign o_busy  = (state != IDLE);
  assign beat    = i_valid & o_ready;

  // XNOR accumulates as XOR and NAND/NOR accumulate as AND/OR; the inversion
  // is applied only once, when the final result is registered.
  always_comb begin
    acc_next = acc ^ i_data;
    case (code_q)
      2'b01:   acc_next = acc & i_data;
      2'b10:   acc_next = acc | i_data;
      default: ;
    endcase
    result = (code_q == 2'b00) ? acc_next : ~acc_next;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      code_q  <= 2'b00;
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Abort takes priority over a coincident beat.
          if (i_abort) begin
            cnt <= '0;
          end else if (beat) begin
            acc    <= i_data;
            code_q <= i_code;
            cnt    <= CNT_W'(1);
            state  <= ACCUM;
          end
        end
        ACCUM: begin
          if (i_abort) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (beat) begin
            acc <= acc_next;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_CNT) begin
              o_data  <= result;
              o_valid <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          // Abort is deliberately ignored here: a finished result must drain.
          if (i_ready) begin
            o_valid <= 1'b0;
            cnt     <= '0;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reduce_gate_seq_v.sv
`default_nettype none
// ============================================================================
// Module      : tb_reduce_gate_seq_v
// Description : Self-checking bench for reduce_gate_seq_v (NUM_OPS=3 and a
//               NUM_OPS=2 instance) with directed and random transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reduce_gate_seq_v;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] code;
  logic       valid;
  logic [7:0] data;
  logic       ready_out;
  logic       abort;
  logic       res_valid;
  logic [7:0] res_data;
  logic       cons_ready;
  logic       busy;

  logic [1:0] code2;
  logic       valid2;
  logic [7:0] data2;
  logic       ready_out2;
  logic       abort2;
  logic       res_valid2;
  logic [7:0] res_data2;
  logic       cons_ready2;
  logic       busy2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reduce_gate_seq_v #(.WIDTH(8), .NUM_OPS(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_code(code), .i_valid(valid), .i_data(data),
    .o_ready(ready_out), .i_abort(abort), .o_valid(res_valid), .o_data(res_data),
    .i_ready(cons_ready), .o_busy(busy)
  );

  reduce_gate_seq_v #(.WIDTH(8), .NUM_OPS(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_code(code2), .i_valid(valid2), .i_data(data2),
    .o_ready(ready_out2), .i_abort(abort2), .o_valid(res_valid2), .o_data(res_data2),
    .i_ready(cons_ready2), .o_busy(busy2)
  );

  // Reference: fold all operands with the base operator, invert unless XOR.
  function automatic logic [7:0] ref_result(input logic [1:0] c, input logic [7:0] v [0:2], input int n);
    logic [7:0] r;
    r = v[0];
    for (int k = 1; k < n; k++) begin
      case (c)
        2'b01:   r = r & v[k];
        2'b10:   r = r | v[k];
        default: r = r ^ v[k];
      endcase
    end
    return (c == 2'b00) ? r : ~r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic [1:0] c);
    valid = 1'b1; data = d; code = c;
    tick();
    valid = 1'b0;
  endtask

  task automatic beat2(input logic [7:0] d, input logic [1:0] c);
    valid2 = 1'b1; data2 = d; code2 = c;
    tick();
    valid2 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; code = 2'b00; valid = 1'b0; data = 8'h00; abort = 1'b0; cons_ready = 1'b0;
    code2 = 2'b00; valid2 = 1'b0; data2 = 8'h00; abort2 = 1'b0; cons_ready2 = 1'b0;
    tick(); tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", res_valid); end
    checks++; if (res_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", res_data); end
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    #1;
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", ready_out); end
    tick();
  endtask

  task automatic test_xor_xnor();
    logic [7:0] v [0:2];
    logic [1:0] c;
    v[0] = 8'h0F; v[1] = 8'h33; v[2] = 8'h55;
    cons_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      c = (i == 0) ? 2'b00 : 2'b11;
      beat(v[0], c); beat(v[1], c); beat(v[2], c);
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL xor_valid code=%b: got %b want 1", c, res_valid); end
      checks++; if (res_data !== ref_result(c, v, 3)) begin errors++; $display("FAIL xor_data code=%b: got %h want %h", c, res_data, ref_result(c, v, 3)); end
      checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL done_ready: got %b want 0", ready_out); end
      tick();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL xor_pulse code=%b: got %b want 0", c, res_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL xor_idle code=%b: got %b want 0", c, busy); end
    end
    cons_ready = 1'b0;
  endtask

  task automatic test_nand_nor();
    logic [7:0] v [0:2];
    cons_ready = 1'b1;
    v[0] = 8'hFF; v[1] = 8'hF0; v[2] = 8'h3C;
    beat(v[0], 2'b01); beat(v[1], 2'b01); beat(v[2], 2'b01);
    checks++; if (res_valid !== 1'b1 || res_data !== 8'hCF) begin errors++; $display("FAIL nand: got v=%b d=%h want v=1 d=cf", res_valid, res_data); end
    tick();
    v[0] = 8'h01; v[1] = 8'h02; v[2] = 8'h04;
    beat(v[0], 2'b10); beat(v[1], 2'b10); beat(v[2], 2'b10);
    checks++; if (res_valid !== 1'b1 || res_data !== ref_result(2'b10, v, 3)) begin errors++; $display("FAIL nor: got v=%b d=%h want v=1 d=%h", res_valid, res_data, ref_result(2'b10, v, 3)); end
    tick();
    cons_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    cons_ready = 1'b0;
    beat(8'h0F, 2'b00); beat(8'h33, 2'b00); beat(8'h55, 2'b00);
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1; data = 8'hFF;
      checks++; if (res_valid !== 1'b1 || res_data !== 8'h69) begin errors++; $display("FAIL bp_hold cyc%0d: got v=%b d=%h want v=1 d=69", i, res_valid, res_data); end
      checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL bp_ready cyc%0d: got %b want 0", i, ready_out); end
      tick();
    end
    cons_ready = 1'b1;
    tick();
    valid = 1'b0;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release: got v=%b busy=%b want 0 0", res_valid, busy); end
    checks++; if (res_data !== 8'h69) begin errors++; $display("FAIL bp_data_keep: got %h want 69", res_data); end
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL bp_ready_idle: got %b want 1", ready_out); end
    cons_ready = 1'b0;
  endtask

  task automatic test_gaps_code_change();
    cons_ready = 1'b0;
    beat(8'h0F, 2'b00);
    code = 2'b01; tick(); tick();
    checks++; if (busy !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL gap_hold: got busy=%b v=%b want 1 0", busy, res_valid); end
    beat(8'h33, 2'b01);
    tick();
    beat(8'h55, 2'b01);
    checks++; if (res_valid !== 1'b1 || res_data !== 8'h69) begin errors++; $display("FAIL gap_code: got v=%b d=%h want v=1 d=69", res_valid, res_data); end
    cons_ready = 1'b1; tick(); cons_ready = 1'b0;
  endtask

  task automatic test_abort();
    logic [7:0] v [0:2];
    cons_ready = 1'b1;
    beat(8'hFF, 2'b10); beat(8'hFF, 2'b10);
    abort = 1'b1; valid = 1'b1; data = 8'hFF;
    tick();
    abort = 1'b0; valid = 1'b0;
    checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy=%b v=%b want 0 0", busy, res_valid); end
    v[0] = 8'h01; v[1] = 8'h02; v[2] = 8'h04;
    beat(v[0], 2'b10); beat(v[1], 2'b10);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL abort_count: got v=%b want 0", res_valid); end
    beat(v[2], 2'b10);
    checks++; if (res_valid !== 1'b1 || res_data !== ref_result(2'b10, v, 3)) begin errors++; $display("FAIL abort_next: got v=%b d=%h want v=1 d=%h", res_valid, res_data, ref_result(2'b10, v, 3)); end
    tick();
    cons_ready = 1'b0;
  endtask

  task automatic test_abort_in_done();
    cons_ready = 1'b0;
    beat(8'h0F, 2'b00); beat(8'h33, 2'b00); beat(8'h55, 2'b00);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (res_valid !== 1'b1 || res_data !== 8'h69 || busy !== 1'b1) begin errors++; $display("FAIL abort_done: got v=%b d=%h busy=%b want 1 69 1", res_valid, res_data, busy); end
    cons_ready = 1'b1; tick(); cons_ready = 1'b0;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL abort_done_drain: got %b want 0", res_valid); end
  endtask

  task automatic test_async_reset();
    logic [7:0] v [0:2];
    cons_ready = 1'b0;
    beat(8'hFF, 2'b00); beat(8'h0F, 2'b00);
    #3 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || ready_out !== 1'b0 || res_valid !== 1'b0 || res_data !== 8'h00) begin
      errors++; $display("FAIL arst_accum: got busy=%b rdy=%b v=%b d=%h want 0 0 0 00", busy, ready_out, res_valid, res_data);
    end
    tick();
    rst = 1'b0;
    v[0] = 8'h12; v[1] = 8'h34; v[2] = 8'h56;
    beat(v[0], 2'b00);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL arst_partial_lost: got v=%b want 0", res_valid); end
    beat(v[1], 2'b00); beat(v[2], 2'b00);
    checks++; if (res_valid !== 1'b1 || res_data !== ref_result(2'b00, v, 3)) begin errors++; $display("FAIL arst_new_txn: got v=%b d=%h want v=1 d=%h", res_valid, res_data, ref_result(2'b00, v, 3)); end
    #3 rst = 1'b1;
    #1;
    checks++; if (res_valid !== 1'b0 || res_data !== 8'h00 || ready_out !== 1'b0) begin
      errors++; $display("FAIL arst_done: got v=%b d=%h rdy=%b want 0 00 0", res_valid, res_data, ready_out);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL arst_after: got v=%b busy=%b want 0 0", res_valid, busy); end
  endtask

  task automatic test_num_ops2();
    logic [7:0] v [0:2];
    logic [1:0] c;
    cons_ready2 = 1'b1;
    beat2(8'hAA, 2'b00); beat2(8'h0F, 2'b00);
    checks++; if (res_valid2 !== 1'b1 || res_data2 !== 8'hA5) begin errors++; $display("FAIL n2_xor: got v=%b d=%h want v=1 d=a5", res_valid2, res_data2); end
    tick();
    for (int t = 0; t < 8; t++) begin
      c = 2'($urandom_range(0, 3));
      v[0] = 8'($urandom); v[1] = 8'($urandom); v[2] = 8'h00;
      beat2(v[0], c); beat2(v[1], 2'($urandom));
      checks++; if (res_valid2 !== 1'b1 || res_data2 !== ref_result(c, v, 2)) begin errors++; $display("FAIL n2_rand t%0d: got v=%b d=%h want v=1 d=%h", t, res_valid2, res_data2, ref_result(c, v, 2)); end
      tick();
    end
    cons_ready2 = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] v [0:2];
    logic [1:0] c;
    logic [7:0] exp;
    int w;
    cons_ready = 1'b0;
    for (int t = 0; t < 30; t++) begin
      c = 2'($urandom_range(0, 3));
      for (int k = 0; k < 3; k++) v[k] = 8'($urandom);
      exp = ref_result(c, v, 3);
      for (int k = 0; k < 3; k++) begin
        w = $urandom_range(0, 2);
        for (int g = 0; g < w; g++) begin
          data = 8'($urandom); code = 2'($urandom);
          tick();
        end
        beat(v[k], (k == 0) ? c : 2'($urandom));
      end
      checks++; if (res_valid !== 1'b1 || res_data !== exp) begin errors++; $display("FAIL rand t%0d: got v=%b d=%h want v=1 d=%h", t, res_valid, res_data, exp); end
      w = $urandom_range(0, 3);
      for (int g = 0; g < w; g++) begin
        valid = 1'($urandom); data = 8'($urandom);
        tick();
        checks++; if (res_valid !== 1'b1 || res_data !== exp) begin errors++; $display("FAIL rand_hold t%0d: got v=%b d=%h want v=1 d=%h", t, res_valid, res_data, exp); end
      end
      valid = 1'b0;
      cons_ready = 1'b1; tick(); cons_ready = 1'b0;
      checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rand_drain t%0d: got v=%b busy=%b want 0 0", t, res_valid, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_xor_xnor();
    test_nand_nor();
    test_backpressure();
    test_gaps_code_change();
    test_abort();
    test_abort_in_done();
    test_async_reset();
    test_num_ops2();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
